uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Transmit-side byte buffer between the processor's UARTwr path and the UART transmitter.
//   Stores up to 16 bytes. Raises txStart while non-empty. The transmitter's txDoneTick
//   is the read strobe. The popped byte is presented on dout one cycle later, while the
//   transmitter is in its start state sampling din. Status feeds the UARTstat accumulator mux.
// PARAMETERS
//   dataBits       8   width of each stored byte
//   fifoWidth      4   pointer (address) width
//   fifoDepth      16  number of entries; must equal 2**fifoWidth
//   fifoCntrWidth  5   occupancy counter width (fifoWidth+1), range 0..16
// PORTS
//   clk       in   1              system clock, rising edge
//   reset     in   1              asynchronous, active-high reset
//   wr        in   1              write strobe from CU (UARTwr); one byte per high cycle
//   wrData    in   dataBits       byte to enqueue, sampled when wr=1
//   rd        in   1              read strobe; tie to transmitter txDoneTick
//   dout      out  dataBits       registered head byte; tie to transmitter din
//   txStart   out  1              = !empty; tie to transmitter txStart
//   empty     out  1              count==0
//   full      out  1              count==fifoDepth
//   count     out  fifoCntrWidth  current occupancy
//   overflow  out  1              sticky: a write was attempted while full
//   clrOvf    in   1              synchronous clear of overflow
// BEHAVIOUR
//   - Reset: wrPtr=0, rdPtr=0, count=0, dout=0, overflow=0, empty=1, full=0, txStart=0.
//     Memory contents are not reset.
//   - Reset mid-operation discards all queued bytes immediately (asynchronous).
//   - Write: if wr && (!full || rd_eff), then mem[wrPtr]<=wrData and wrPtr<=wrPtr+1.
//   - Write while full with no effective read is dropped. It sets overflow on the same edge.
//   - Read: rd_eff = rd && !empty. If rd_eff, dout<=mem[rdPtr] and rdPtr<=rdPtr+1.
//     dout is valid from the cycle after the rd pulse and holds until the next effective read.
//   - Read while empty is ignored: dout, rdPtr and count are unchanged.
//   - Count: +1 on effective write only, -1 on effective read only, unchanged when both or neither.
//   - Simultaneous rd & wr when full: both complete, count stays 16.
//   - Simultaneous rd & wr when empty: the write completes, the read is ignored, count becomes 1.
//     No bypass from wrData to dout.
//   - Pointers wrap modulo fifoDepth (15 -> 0). Full/empty come from count, not pointer compare.
//   - Latency: a byte written at edge N makes txStart=1 after edge N.
//     Its value appears on dout one cycle after the rd pulse that selects it.
//   - overflow: set has priority over clrOvf when both occur in one cycle.
//   - empty, full and txStart are combinational decodes of registered count. There is no
//     other combinational path from input to output.
//   - rd is expected as a single-cycle pulse. Back-to-back rd pulses pop consecutive entries.
// STRUCTURE
//   - dataBits, fifoWidth, fifoDepth and fifoCntrWidth come from the shared UART defines.
//     Add no new constants beyond them.
//   - One sub-module: uart_fifo_mem. It is a fifoDepth x dataBits register array with one
//     synchronous write port and one combinational read port.
//   - uart_tx_fifo holds the pointers, counter, dout register and flags.
// TESTING
//   1 Reset, then write 0xA5 once. Expect count=1, txStart=1. Pulse rd 3 cycles later.
//     Expect dout=0xA5 on the next cycle, then count=0, empty=1.
//   2 Write 0x00..0x0F on 16 consecutive cycles. Expect full=1, count=16.
//     A 17th write of 0xFF is dropped with overflow=1. Pulse clrOvf: overflow=0.
//     Sixteen rd pulses return 0x00..0x0F in order.
//   3 At full, issue rd and wr(0x77) in the same cycle. Expect count=16 and no overflow.
//     After draining, 0x77 is the last byte out.
//   4 Pulse rd while empty. Expect dout, count and rdPtr unchanged.
//     Then rd and wr(0x3C) together on empty: count=1, dout unchanged.
//   5 Wrap: run 40 writes/reads interleaved at 1-2 occupancy.
//     Expect the data order preserved across pointer wrap 15->0.
//   6 With 5 bytes queued, assert reset for 1 cycle mid-stream. Expect count=0, empty=1,
//     txStart=0, dout=0 immediately. The next write/read pair operates normally.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART constants for the transmit-side byte buffer.
package uart_tx_fifo_pkg;
  localparam int dataBits      = 8;
  localparam int fifoWidth     = 4;
  localparam int fifoDepth     = 16;
  localparam int fifoCntrWidth = 5;
endpackage

// File: rtl/uart_fifo_mem.sv
// fifoDepth x dataBits register array: one synchronous write port, one combinational read port.
module uart_fifo_mem
  import uart_tx_fifo_pkg::*;
(
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [fifoWidth-1:0] waddr_i,
  input  logic [dataBits-1:0]  wdata_i,
  input  logic [fifoWidth-1:0] raddr_i,
  output logic [dataBits-1:0]  rdata_o
);

  // Contents are deliberately not reset; occupancy tracking alone decides what is valid.
  logic [dataBits-1:0] mem_q [fifoDepth];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer: pointers, occupancy counter, registered dout and sticky overflow.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [dataBits-1:0]      wrData,
  input  logic                     rd,
  output logic [dataBits-1:0]      dout,
  output logic                     txStart,
  output logic                     empty,
  output logic                     full,
  output logic [fifoCntrWidth-1:0] count,
  output logic                     overflow,
  input  logic                     clrOvf
);

  // Handshake: wr is accepted when not full, or when a same-cycle effective read frees a slot;
  // rd is a single-cycle pop strobe accepted only when non-empty, and the popped byte is
  // presented on dout from the next cycle until the next accepted rd.
  logic [fifoWidth-1:0]     wr_ptr_q, wr_ptr_d;
  logic [fifoWidth-1:0]     rd_ptr_q, rd_ptr_d;
  logic [fifoCntrWidth-1:0] count_q, count_d;
  logic [dataBits-1:0]      dout_q, dout_d;
  logic                     ovf_q, ovf_d;
  logic [dataBits-1:0]      mem_rdata;
  logic                     rd_eff, wr_eff;

  assign empty   = (count_q == '0);
  assign full    = (count_q == fifoCntrWidth'(fifoDepth));
  assign txStart = !empty;
  assign rd_eff  = rd && !empty;
  assign wr_eff  = wr && (!full || rd_eff);

  uart_fifo_mem u_mem (
    .clk     (clk),
    .we_i    (wr_eff),
    .waddr_i (wr_ptr_q),
    .wdata_i (wrData),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    ovf_d    = ovf_q;
    if (wr_eff) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_eff) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem_rdata;
    end
    case ({wr_eff, rd_eff})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A dropped write wins over a same-cycle clear so the event is never lost.
    if (wr && !wr_eff)  ovf_d = 1'b1;
    else if (clrOvf)    ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign dout     = dout_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: scenario tasks against a queue-based reference model.
module tb_uart_tx_fifo;
  import uart_tx_fifo_pkg::*;

  logic                     clk;
  logic                     reset;
  logic                     wr;
  logic [dataBits-1:0]      wrData;
  logic                     rd;
  logic [dataBits-1:0]      dout;
  logic                     txStart;
  logic                     empty;
  logic                     full;
  logic [fifoCntrWidth-1:0] count;
  logic                     overflow;
  logic                     clrOvf;

  int checks = 0;
  int errors = 0;

  logic [dataBits-1:0] exp_q[$];
  int                  m_cnt  = 0;
  logic [dataBits-1:0] m_dout = '0;
  logic                m_ovf  = 1'b0;
  logic                popped = 1'b0;

  uart_tx_fifo dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .wrData   (wrData),
    .rd       (rd),
    .dout     (dout),
    .txStart  (txStart),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .clrOvf   (clrOvf)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    reset  = 1'b1;
    wr     = 1'b0;
    wrData = '0;
    rd     = 1'b0;
    clrOvf = 1'b0;
  end

  // Driver: called at a falling edge, applies one cycle of stimulus, updates the model and
  // returns at the next falling edge with inputs idle and DUT outputs settled.
  task automatic drive_cycle(input logic w, input logic [dataBits-1:0] d, input logic r,
                             input logic c);
    logic r_eff, w_eff;
    wr = w; wrData = d; rd = r; clrOvf = c;
    r_eff  = r && (m_cnt > 0);
    w_eff  = w && ((m_cnt < fifoDepth) || r_eff);
    popped = r_eff;
    if (r_eff) begin
      m_dout = exp_q.pop_front();
      m_cnt--;
    end
    if (w_eff) begin
      exp_q.push_back(d);
      m_cnt++;
    end
    if (w && !w_eff) m_ovf = 1'b1;
    else if (c)      m_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0; wrData = '0; rd = 1'b0; clrOvf = 1'b0;
  endtask

  task automatic apply_reset_mid();
    reset = 1'b1;
    exp_q.delete();
    m_cnt = 0; m_dout = '0; m_ovf = 1'b0; popped = 1'b0;
    #1;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || txStart !== 1'b0 || dout !== 8'h00 ||
        full !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_immediate: count=%0d empty=%b txStart=%b dout=%h full=%b ovf=%b required 0/1/0/00/0/0",
               count, empty, txStart, dout, full, overflow);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    apply_reset_mid();
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_release: count=%0d empty=%b dout=%h required 0/1/00", count, empty, dout);
    end
  endtask

  task automatic test_single();
    drive_cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd1 || txStart !== 1'b1) begin
      errors++;
      $display("FAIL single_write: count=%0d txStart=%b required 1/1", count, txStart);
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (dout !== 8'hA5 || count !== 5'd0 || empty !== 1'b1 || txStart !== 1'b0) begin
      errors++;
      $display("FAIL single_read: dout=%h count=%0d empty=%b txStart=%b required a5/0/1/0",
               dout, count, empty, txStart);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < fifoDepth; i++) drive_cycle(1'b1, 8'(i), 1'b0, 1'b0);
    checks++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill: full=%b count=%0d ovf=%b required 1/16/0", full, count, overflow);
    end
    drive_cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      errors++;
      $display("FAIL overflow_set: ovf=%b count=%0d required 1/16", overflow, count);
    end
    drive_cycle(1'b1, 8'hEE, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_priority: ovf=%b required 1", overflow);
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: ovf=%b required 0", overflow);
    end
    for (int i = 0; i < fifoDepth; i++) begin
      drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (dout !== m_dout || dout !== 8'(i) || count !== 5'(m_cnt)) begin
        errors++;
        $display("FAIL drain_order[%0d]: dout=%h count=%0d required %h/%0d", i, dout, count,
                 m_dout, m_cnt);
      end
    end
  endtask

  task automatic test_full_rdwr();
    for (int i = 0; i < fifoDepth; i++)
      drive_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    drive_cycle(1'b1, 8'h77, 1'b1, 1'b0);
    checks++;
    if (count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1 || dout !== m_dout) begin
      errors++;
      $display("FAIL full_rdwr: count=%0d ovf=%b full=%b dout=%h required 16/0/1/%h",
               count, overflow, full, dout, m_dout);
    end
    while (m_cnt > 0) begin
      drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (dout !== m_dout) begin
        errors++;
        $display("FAIL full_rdwr_drain: dout=%h required %h", dout, m_dout);
      end
    end
    checks++;
    if (dout !== 8'h77 || empty !== 1'b1) begin
      errors++;
      $display("FAIL full_rdwr_last: dout=%h empty=%b required 77/1", dout, empty);
    end
  endtask

  task automatic test_empty_rd();
    logic [dataBits-1:0] held;
    held = m_dout;
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (dout !== held || count !== 5'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL empty_rd: dout=%h count=%0d empty=%b required %h/0/1", dout, count, empty, held);
    end
    drive_cycle(1'b1, 8'h3C, 1'b1, 1'b0);
    checks++;
    if (count !== 5'd1 || dout !== held || txStart !== 1'b1) begin
      errors++;
      $display("FAIL empty_rdwr: count=%0d dout=%h txStart=%b required 1/%h/1", count, dout,
               txStart, held);
    end
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (dout !== 8'h3C || count !== 5'd0) begin
      errors++;
      $display("FAIL empty_rdwr_pop: dout=%h count=%0d required 3c/0", dout, count);
    end
  endtask

  task automatic test_wrap();
    drive_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) drive_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      else            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (dout !== m_dout || count !== 5'(m_cnt)) begin
        errors++;
        $display("FAIL wrap[%0d]: dout=%h count=%0d required %h/%0d", i, dout, count, m_dout, m_cnt);
      end
    end
    while (m_cnt > 0) begin
      drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (dout !== m_dout) begin
        errors++;
        $display("FAIL wrap_drain: dout=%h required %h", dout, m_dout);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (count !== 5'd4 || dout !== 8'h50) begin
      errors++;
      $display("FAIL pre_reset: count=%0d dout=%h required 4/50", count, dout);
    end
    apply_reset_mid();
    drive_cycle(1'b1, 8'hC3, 1'b0, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (dout !== 8'hC3 || count !== 5'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_pair: dout=%h count=%0d empty=%b required c3/0/1", dout, count, empty);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_rdwr();
    test_empty_rd();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
